// File: rtl/siggen_pkg.sv
// siggen_pkg: shared mode/state encodings and the Galois LFSR step used by the signal generator
package siggen_pkg;
  typedef enum logic [1:0] {MODE_RANDOM, MODE_RAMP, MODE_CONST, MODE_SQUARE} mode_t;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] SEED_SPREAD = 32'h9E37_79B9;
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction
endpackage

// File: rtl/siggen_lfsr32.sv
// siggen_lfsr32: 32-bit Galois LFSR with seed reload and advance enable
module siggen_lfsr32 import siggen_pkg::*; #(
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        en,
  output logic [31:0] state
);
  always_ff @(posedge clk) begin
    if (rst || load) state <= SEED;
    else if (en) state <= lfsr_next(state);
  end
endmodule

// File: rtl/multichannel_signal_generator.sv
// multichannel_signal_generator: NUM_CH-channel random/ramp/constant/square stimulus source, valid/ready output
// Define SIGGEN_NOISE_EN to add saturating LFSR noise to ramp, constant and square modes.
module multichannel_signal_generator import siggen_pkg::*; #(
  parameter int          WIDTH       = 16,
  parameter int          NUM_CH      = 2,
  parameter int          CNT_W       = 16,
  parameter logic [31:0] SEED        = 32'hACE1_2025,
  parameter int          HALF_PERIOD = 8,
  parameter int          NOISE_BITS  = 4
) (
  input  logic                    clk_operation,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [1:0]              mode,
  input  logic [CNT_W-1:0]        num_samples,
  input  logic [WIDTH-1:0]        step,
  input  logic [WIDTH-1:0]        const_value,
  input  logic                    sample_tick,
  input  logic                    out_ready,
  output logic [WIDTH*NUM_CH-1:0] signal,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);
  localparam int PH_W = HALF_PERIOD > 1 ? $clog2(HALF_PERIOD) : 1;
  if (WIDTH < 2 || WIDTH > 32 || NUM_CH < 1 || NUM_CH > 8 || HALF_PERIOD < 1 || NOISE_BITS < 2 || NOISE_BITS > WIDTH) begin : g_bad_params
    $error("multichannel_signal_generator: parameter out of range");
  end
  state_t state;
  mode_t md;
  logic [CNT_W-1:0] n, count;
  logic [WIDTH-1:0] stp, cval, acc;
  logic [PH_W-1:0] ph;
  logic neg, load, accept, adv;
  logic [WIDTH*NUM_CH-1:0] nxt_sig;
  assign load = state == ST_IDLE && start;
  assign accept = state == ST_RUN && !abort && sample_tick && (!out_valid || out_ready) && count != n;
`ifdef SIGGEN_NOISE_EN
  assign adv = accept;
  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] b, input logic [NOISE_BITS-1:0] r);
    logic [WIDTH:0] s;
    s = {b[WIDTH-1], b} + (WIDTH+1)'($signed({~r[NOISE_BITS-1], r[NOISE_BITS-2:0]}));
    return s[WIDTH] == s[WIDTH-1] ? s[WIDTH-1:0] : {s[WIDTH], {(WIDTH-1){~s[WIDTH]}}};
  endfunction
`else
  assign adv = accept && md == MODE_RANDOM;
`endif
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [31:0] S = SEED ^ (32'(c) * SEED_SPREAD);
    logic [31:0] st;
    logic [WIDTH-1:0] base;
    siggen_lfsr32 #(.SEED(S == 32'h0 ? 32'h1 : S)) u_lfsr (
      .clk(clk_operation), .rst(reset), .load(load), .en(adv), .state(st)
    );
    assign base = md == MODE_RAMP ? acc + stp : md == MODE_CONST ? cval : neg ? -cval : cval;
`ifdef SIGGEN_NOISE_EN
    assign nxt_sig[c*WIDTH +: WIDTH] = md == MODE_RANDOM ? WIDTH'(lfsr_next(st)) : sat_add(base, NOISE_BITS'(lfsr_next(st)));
`else
    assign nxt_sig[c*WIDTH +: WIDTH] = md == MODE_RANDOM ? WIDTH'(lfsr_next(st)) : base;
`endif
  end
  always_ff @(posedge clk_operation) begin
    if (reset) begin
      state <= ST_IDLE;
      md <= MODE_RANDOM;
      n <= '0;
      count <= '0;
      stp <= '0;
      cval <= '0;
      acc <= '0;
      ph <= '0;
      neg <= 1'b0;
      signal <= '0;
      out_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          md <= mode_t'(mode);
          n <= num_samples;
          stp <= step;
          cval <= const_value;
          count <= '0;
          overrun <= 1'b0;
          acc <= '0;
          ph <= '0;
          neg <= 1'b0;
          state <= num_samples == '0 ? ST_DONE : ST_RUN;
          busy <= num_samples != '0;
        end
        ST_RUN: if (abort) begin
          state <= ST_IDLE;
          busy <= 1'b0;
          out_valid <= 1'b0;
        end else if (count == n && !out_valid) begin
          state <= ST_DONE;
          busy <= 1'b0;
        end else begin
          if (accept) begin
            signal <= nxt_sig;
            out_valid <= 1'b1;
            count <= count + 1'b1;
            acc <= acc + stp;
            ph <= ph == PH_W'(HALF_PERIOD - 1) ? '0 : ph + 1'b1;
            neg <= ph == PH_W'(HALF_PERIOD - 1) ? ~neg : neg;
          end else if (out_ready) out_valid <= 1'b0;
          // a tick that finds the output still held is lost; generators stay put
          if (sample_tick && out_valid && !out_ready && count != n) overrun <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          done <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_multichannel_signal_generator.sv
// tb_multichannel_signal_generator: directed self-checking bench for multichannel_signal_generator
module tb_multichannel_signal_generator;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, sample_tick = 1'b0, out_ready = 1'b1;
  logic [1:0] mode = '0;
  logic [15:0] num_samples = '0, step = '0, const_value = '0;
  logic [31:0] signal;
  logic out_valid, busy, done, overrun;
  int checks = 0, errors = 0, done_cnt = 0;
  logic [31:0] m0, m1, first;
  logic [15:0] ramp_exp [6] = '{16'h4000, 16'h8000, 16'hC000, 16'h0000, 16'h4000, 16'h8000};
  logic [15:0] sq_exp [6] = '{16'd100, 16'd100, 16'hFF9C, 16'hFF9C, 16'd100, 16'd100};
  multichannel_signal_generator #(
    .WIDTH(16), .NUM_CH(2), .CNT_W(16), .SEED(32'hACE1_2025), .HALF_PERIOD(2), .NOISE_BITS(4)
  ) dut (
    .clk_operation(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .num_samples(num_samples), .step(step), .const_value(const_value), .sample_tick(sample_tick),
    .out_ready(out_ready), .signal(signal), .out_valid(out_valid), .busy(busy), .done(done), .overrun(overrun)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (done) done_cnt++;
  function automatic logic [31:0] model_next(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction
  function automatic logic [31:0] model_seed(input int c);
    logic [31:0] s;
    s = 32'hACE1_2025 ^ (32'(c) * 32'h9E37_79B9);
    return s == 32'h0 ? 32'h1 : s;
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask
  task automatic run_start(input logic [1:0] m, input logic [15:0] n, input logic [15:0] st, input logic [15:0] cv);
    mode = m;
    num_samples = n;
    step = st;
    const_value = cv;
    start = 1'b1;
    done_cnt = 0;
    cyc();
    start = 1'b0;
  endtask
  task automatic tick();
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
  endtask
  task automatic finish_run(input string tag);
    repeat (8) cyc();
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_busy_after"}, {31'b0, busy}, 0);
  endtask
  initial begin
    repeat (2) cyc();
    chk("reset_signal", signal, 0);
    chk("reset_flags", {28'b0, out_valid, busy, done, overrun}, 0);
    reset = 1'b0;
    cyc();
    // random mode, tick every 4 cycles
    m0 = model_seed(0);
    m1 = model_seed(1);
    run_start(2'd0, 16'd5, 16'd0, 16'd0);
    chk("rand_busy", {31'b0, busy}, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      m0 = model_next(m0);
      m1 = model_next(m1);
      chk($sformatf("rand_sample%0d", i), signal, {m1[15:0], m0[15:0]});
      chk($sformatf("rand_valid%0d", i), {31'b0, out_valid}, 1);
      if (i == 0) chk("rand_ch_differ", {31'b0, signal[15:0] !== signal[31:16]}, 1);
      repeat (3) cyc();
    end
    finish_run("rand");
    // ramp wraps modulo 2^16
    run_start(2'd1, 16'd6, 16'h4000, 16'd0);
    chk("ramp_valid_before", {31'b0, out_valid}, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("ramp_sample%0d", i), signal, {ramp_exp[i], ramp_exp[i]});
      chk($sformatf("ramp_valid%0d", i), {31'b0, out_valid}, 1);
      cyc();
    end
    finish_run("ramp");
    // square, half period 2
    run_start(2'd3, 16'd6, 16'd0, 16'd100);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("sq_sample%0d", i), signal, {sq_exp[i], sq_exp[i]});
      cyc();
    end
    finish_run("sq");
    // backpressure: second tick is dropped and the held sample stays put
    out_ready = 1'b0;
    run_start(2'd1, 16'd3, 16'd1, 16'd0);
    tick();
    chk("bp_first", signal, 32'h0001_0001);
    chk("bp_overrun_clear", {31'b0, overrun}, 0);
    cyc();
    tick();
    chk("bp_held", signal, 32'h0001_0001);
    chk("bp_overrun_set", {31'b0, overrun}, 1);
    chk("bp_valid_held", {31'b0, out_valid}, 1);
    out_ready = 1'b1;
    cyc();
    chk("bp_accepted", {31'b0, out_valid}, 0);
    tick();
    chk("bp_second", signal, 32'h0002_0002);
    cyc();
    tick();
    chk("bp_third", signal, 32'h0003_0003);
    finish_run("bp");
    chk("bp_overrun_sticky", {31'b0, overrun}, 1);
    // zero-length run: done two cycles after start, overrun cleared by start
    run_start(2'd2, 16'd0, 16'd0, 16'd7);
    chk("zero_overrun_cleared", {31'b0, overrun}, 0);
    chk("zero_done_early", {31'b0, done}, 0);
    cyc();
    chk("zero_done_pulse", {31'b0, done}, 1);
    chk("zero_no_valid", {31'b0, out_valid}, 0);
    cyc();
    chk("zero_done_low", {31'b0, done}, 0);
    // abort after 3 of 10 samples, abort beats a simultaneous tick
    m0 = model_seed(0);
    m1 = model_seed(1);
    first = {model_next(m1) & 32'hFFFF} << 16 | (model_next(m0) & 32'hFFFF);
    run_start(2'd0, 16'd10, 16'd0, 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      m0 = model_next(m0);
      m1 = model_next(m1);
      chk($sformatf("abort_sample%0d", i), signal, {m1[15:0], m0[15:0]});
    end
    abort = 1'b1;
    sample_tick = 1'b1;
    cyc();
    abort = 1'b0;
    sample_tick = 1'b0;
    chk("abort_valid", {31'b0, out_valid}, 0);
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_no_new_sample", signal, {m1[15:0], m0[15:0]});
    repeat (4) cyc();
    chk("abort_no_done", done_cnt, 0);
    run_start(2'd0, 16'd1, 16'd0, 16'd0);
    tick();
    chk("restart_first_sample", signal, first);
    finish_run("restart");
    // reset in the middle of a run
    run_start(2'd1, 16'd5, 16'd1, 16'd0);
    tick();
    out_ready = 1'b0;
    tick();
    reset = 1'b1;
    cyc();
    chk("midreset_signal", signal, 0);
    chk("midreset_flags", {28'b0, out_valid, busy, done, overrun}, 0);
    reset = 1'b0;
    out_ready = 1'b1;
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
